// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-way round-robin grant arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Owner hand-off is controlled by the owner_release / request handshake in rr_grant_arbiter16.
package arb_pkg;

    localparam int N_REQ_C = 16;
    localparam int IDX_W_C = 4;

    // Pointer value after reset, so that the first search begins at requester 0.
    localparam logic [IDX_W_C-1:0] RST_PTR = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/gnt_decoder4x16.sv
// Enable-gated 4:16 one-hot decoder that drives the grant vector.
// Latency: combinational. Backpressure: none; the output is all zero while en=0.
// Inputs come only from registers in the arbiter, so no request-to-grant glitch path exists.
module gnt_decoder4x16
    import arb_pkg::*;
(
    input  logic [IDX_W_C-1:0] idx,
    input  logic               en,
    output logic [N_REQ_C-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter16.sv
// Round-robin arbiter: 16 requesters share one resource, with a one-cycle GAP between owners.
// Latency: grant is visible 1 cycle after the request is sampled in IDLE. Backpressure: owner holds until owner_release or req drop.
// Optional hold timeout is built when ARB_TIMEOUT_EN is defined (forced revoke after MAX_HOLD cycles).
module rr_grant_arbiter16
    import arb_pkg::*;
#(
    parameter int N_REQ    = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             owner_release,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    if (N_REQ != N_REQ_C || IDX_W != IDX_W_C) begin : g_bad_width
        $error("rr_grant_arbiter16 supports only N_REQ=16, IDX_W=4");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_grant_arbiter16 MAX_HOLD must be in 1..255");
    end

    // First set bit searching ptr+1 .. ptr with wrap; offset 16 folds back to ptr itself.
    function automatic logic [IDX_W_C-1:0] rr_pick(input logic [N_REQ_C-1:0] r,
                                                    input logic [IDX_W_C-1:0] ptr);
        logic [IDX_W_C-1:0] cand;
        logic [IDX_W_C-1:0] win;
        win = ptr;
        for (int off = N_REQ_C; off >= 1; off--) begin
            cand = ptr + IDX_W_C'(off);
            if (r[cand]) begin
                win = cand;
            end
        end
        return win;
    endfunction

    arb_state_t         state_q, state_d;
    logic [IDX_W_C-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W_C-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W_C-1:0] pick_idx;
    logic               owner_done;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    assign pick_idx   = rr_pick(req, rr_ptr_q);
    assign owner_done = owner_release | ~req[gnt_idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= RST_PTR;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d  = pick_idx;
                    rr_ptr_d   = pick_idx;
                    state_d    = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                // A normal release outranks the timeout on the same cycle.
                if (owner_done) begin
                    state_d = GAP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_valid = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
        timeout   = timeout_q;
`else
        timeout   = 1'b0;
`endif
    end

    assign gnt_idx = gnt_idx_q;

    gnt_decoder4x16 u_gnt_dec (
        .idx    (gnt_idx_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule
